// File: rtl/mp_pkg.sv
// Shared trace-decoder definitions: FSM state encoding and the legal
// per-state din values, usable by both the decoder and the sequencer.
package mp_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        E0   = 3'd1,
        E1   = 3'd2,
        P0   = 3'd3,
        P1   = 3'd4,
        Q    = 3'd5,
        R    = 3'd6,
        A8   = 3'd7
    } state_t;

    // Bit expected in each state for the trace to stay legal.
    localparam logic EXP_E0 = 1'b0;
    localparam logic EXP_E1 = 1'b1;
    localparam logic EXP_P0 = 1'b0;
    localparam logic EXP_P1 = 1'b1;
    localparam logic EXP_A8 = 1'b0;

    // Whole traces, first bit in bit 0.
    localparam int           SHORT_LEN  = 6;
    localparam logic [5:0]   SHORT_BITS = 6'b011010;
    localparam logic [1:0]   LOOP_HEAD  = 2'b10;
    localparam logic [1:0]   LOOP_BODY  = 2'b10;
    localparam logic [1:0]   LOOP_TAIL  = 2'b00;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag.
// Ports: clk, reset_n, clear, inc -> value[CNT_W], sat.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             sat
);

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (value == MAX)
                sat <= 1'b1;
            else
                value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/mp_trace_decoder.sv
// Decodes the serial din trace of the microprogram sequencer.
// Ports: clk, reset_n, start, din -> busy, done, error, path, loop_cnt, sat.
module mp_trace_decoder
    import mp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             din,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             path,
    output logic [CNT_W-1:0] loop_cnt,
    output logic             sat
);

    state_t           state;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_sat;

    // Increment on each accepted loop-closing '1'; start restarts instead.
    assign cnt_inc = !start && din && (state == P1 || state == R);

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start),
        .inc     (cnt_inc),
        .value   (cnt_val),
        .sat     (cnt_sat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            path     <= 1'b0;
            loop_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (start) begin
                // Also a silent abort when a decode is in flight.
                state <= E0;
                busy  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: busy <= 1'b0;
                    E0: begin
                        if (din == EXP_E0) begin
                            state <= E1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                    E1: begin
                        if (din == EXP_E1) begin
                            state <= P0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                    P0: begin
                        if (din == EXP_P0) begin
                            state <= P1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                    P1: begin
                        if (din == EXP_P1) begin
                            state <= Q;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                    Q: begin
                        // A '1' here is only legal straight after P1.
                        if (!din) begin
                            state <= R;
                        end else if (cnt_val == CNT_W'(1)) begin
                            state <= A8;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                    R: begin
                        if (din) begin
                            state <= Q;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            path     <= 1'b1;
                            loop_cnt <= cnt_val;
                            sat      <= cnt_sat;
                        end
                    end
                    A8: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (din == EXP_A8) begin
                            done     <= 1'b1;
                            path     <= 1'b0;
                            loop_cnt <= '0;
                            sat      <= cnt_sat;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mp_trace_decoder.sv
// Directed bench for mp_trace_decoder: default and CNT_W=2 instances
// fed the same start/din stream.
module tb_mp_trace_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       din = 1'b0;

    logic       busy8, done8, error8, path8, sat8;
    logic [7:0] cnt8;
    logic       busy2, done2, error2, path2, sat2;
    logic [1:0] cnt2;

    int total = 0;
    int bad = 0;
    int nd8 = 0;
    int ne8 = 0;

    mp_trace_decoder u8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .din      (din),
        .busy     (busy8),
        .done     (done8),
        .error    (error8),
        .path     (path8),
        .loop_cnt (cnt8),
        .sat      (sat8)
    );

    mp_trace_decoder #(.CNT_W(2)) u2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .din      (din),
        .busy     (busy2),
        .done     (done2),
        .error    (error2),
        .path     (path2),
        .loop_cnt (cnt2),
        .sat      (sat2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic d);
        @(negedge clk);
        start = s;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (done8)  nd8++;
        if (error8) ne8++;
        chk("excl8", {31'd0, done8 & error8}, 32'd0);
    endtask

    task automatic bits(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) step(1'b0, v[i]);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_err",  {31'd0, error8}, 0);
        chk("rst_path", {31'd0, path8}, 0);
        chk("rst_cnt",  {24'd0, cnt8}, 0);
        chk("rst_sat",  {31'd0, sat8}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // short trace 0,1,0,1,1,0
        step(1'b1, 1'b0);
        chk("s_busy", {31'd0, busy8}, 1);
        bits(5, 32'h1A);
        chk("s_nodone_early", {31'd0, done8}, 0);
        step(1'b0, 1'b0);
        chk("s_done", {31'd0, done8}, 1);
        chk("s_err",  {31'd0, error8}, 0);
        chk("s_path", {31'd0, path8}, 0);
        chk("s_cnt",  {24'd0, cnt8}, 0);
        chk("s_sat",  {31'd0, sat8}, 0);
        chk("s_busy0", {31'd0, busy8}, 0);
        step(1'b0, 1'b0);
        chk("s_pulse", {31'd0, done8}, 0);

        // loop N=3: 0,1,0,1,0,1,0,1,0,0
        step(1'b1, 1'b0);
        bits(10, 32'h0AA);
        chk("l3_done",  {31'd0, done8}, 1);
        chk("l3_path",  {31'd0, path8}, 1);
        chk("l3_cnt",   {24'd0, cnt8}, 3);
        chk("l3_sat",   {31'd0, sat8}, 0);
        chk("l3_done2", {31'd0, done2}, 1);
        chk("l3_cnt2",  {30'd0, cnt2}, 3);
        chk("l3_sat2",  {31'd0, sat2}, 0);

        // din=1 in E0
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("e_err",  {31'd0, error8}, 1);
        chk("e_done", {31'd0, done8}, 0);
        chk("e_busy", {31'd0, busy8}, 0);
        chk("e_path", {31'd0, path8}, 1);
        chk("e_cnt",  {24'd0, cnt8}, 3);
        step(1'b0, 1'b0);
        chk("e_pulse", {31'd0, error8}, 0);

        // '1' in Q after the loop started: 0,1,0,1,0,1,1
        step(1'b1, 1'b0);
        bits(7, 32'h6A);
        chk("q_err",  {31'd0, error8}, 1);
        chk("q_cnt",  {24'd0, cnt8}, 3);

        // loop N=5, saturates the 2-bit counter
        step(1'b1, 1'b0);
        bits(14, 32'hAAA);
        chk("l5_done",  {31'd0, done8}, 1);
        chk("l5_cnt",   {24'd0, cnt8}, 5);
        chk("l5_sat",   {31'd0, sat8}, 0);
        chk("l5_done2", {31'd0, done2}, 1);
        chk("l5_path2", {31'd0, path2}, 1);
        chk("l5_cnt2",  {30'd0, cnt2}, 3);
        chk("l5_sat2",  {31'd0, sat2}, 1);

        // abort after 4 bits, then a full short trace
        nd8 = 0;
        ne8 = 0;
        step(1'b1, 1'b0);
        bits(4, 32'h0A);
        step(1'b1, 1'b1);
        bits(6, 32'h1A);
        step(1'b0, 1'b0);
        chk("ab_ndone", nd8, 1);
        chk("ab_nerr",  ne8, 0);
        chk("ab_path",  {31'd0, path8}, 0);
        chk("ab_cnt",   {24'd0, cnt8}, 0);
        chk("ab_sat2",  {31'd0, sat2}, 0);

        // reset while in R, then din activity without start
        step(1'b1, 1'b0);
        bits(5, 32'h0A);
        chk("r_busy_pre", {31'd0, busy8}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_busy", {31'd0, busy8}, 0);
        chk("r_done", {31'd0, done8}, 0);
        chk("r_err",  {31'd0, error8}, 0);
        chk("r_path", {31'd0, path8}, 0);
        chk("r_cnt",  {24'd0, cnt8}, 0);
        chk("r_sat",  {31'd0, sat8}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd8 = 0;
        ne8 = 0;
        bits(12, 32'h31A);
        chk("r_ndone", nd8, 0);
        chk("r_nerr",  ne8, 0);
        chk("r_idle",  {31'd0, busy8}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
